// File: rtl/teak_action_stub_pkg.sv
// ----------------------------------------------------------------------------
// teak_action_stub_pkg
// Shared types and constants for the kernel-action stub: the control FSM
// state encoding, the AXI-lite register indices and the AXI response codes.
// ----------------------------------------------------------------------------
package teak_action_stub_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH_ADDR,
        ST_FETCH_DATA,
        ST_DELAY,
        ST_DONE
    } state_t;

    localparam int CHECKSUM_IDX = 0;
    localparam int RUNCOUNT_IDX = 1;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

endpackage

// File: rtl/teak_action_stub_axi_regs.sv
// ----------------------------------------------------------------------------
// teak_action_stub_axi_regs
// AXI-lite slave for the action stub. Word index 0 returns the parameter
// checksum, index 1 the run counter (both read-only, writes ignored with
// OKAY), indices 2..AXI_REGS-1 are byte-writable scratch registers.
// Addresses at or beyond 4*AXI_REGS answer SLVERR with read data 0.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   i_checksum            parameter checksum from the control FSM
//   i_run_count           completed-run counter from the control FSM
//   s_axi_ar*/r*          read address / read data channels
//   s_axi_aw*/w*/b*       write address / write data / write response
// ----------------------------------------------------------------------------
module teak_action_stub_axi_regs
    import teak_action_stub_pkg::*;
#(
    parameter int AXI_REGS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] i_checksum,
    input  logic [31:0] i_run_count,
    input  logic [31:0] s_axi_araddr,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    output logic [31:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready,
    input  logic [31:0] s_axi_awaddr,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [31:0] s_axi_wdata,
    input  logic [3:0]  s_axi_wstrb,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    output logic [1:0]  s_axi_bresp,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready
);

    localparam int          IDX_W      = $clog2(AXI_REGS);
    localparam logic [31:0] ADDR_LIMIT = 32'(4 * AXI_REGS);

    logic [31:0]      r_scratch [AXI_REGS-1:2];
    logic             r_arready;
    logic             r_rvalid;
    logic [31:0]      r_rdata;
    logic [1:0]       r_rresp;
    logic             r_aw_wready;
    logic             r_bvalid;
    logic [1:0]       r_bresp;

    logic [IDX_W-1:0] w_rd_idx;
    logic [IDX_W-1:0] w_wr_idx;
    logic             w_rd_bad;
    logic             w_wr_bad;
    logic [31:0]      w_rd_data;

    assign w_rd_idx = s_axi_araddr[2 +: IDX_W];
    assign w_wr_idx = s_axi_awaddr[2 +: IDX_W];
    assign w_rd_bad = (s_axi_araddr >= ADDR_LIMIT);
    assign w_wr_bad = (s_axi_awaddr >= ADDR_LIMIT);

    // NOTE: every signal driven here gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        w_rd_data = '0;
        if (w_rd_bad)
            w_rd_data = '0;
        else if (w_rd_idx == IDX_W'(CHECKSUM_IDX))
            w_rd_data = i_checksum;
        else if (w_rd_idx == IDX_W'(RUNCOUNT_IDX))
            w_rd_data = i_run_count;
        else
            w_rd_data = r_scratch[w_rd_idx];
    end

    // Read machine: arready pulses for one cycle after arvalid is seen, the
    // data is captured in that same cycle, and rvalid then holds until rready.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= OKAY;
        end else begin
            r_arready <= 1'b0;
            if (r_arready) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_data;
                r_rresp  <= w_rd_bad ? SLVERR : OKAY;
            end else if (r_rvalid) begin
                if (s_axi_rready)
                    r_rvalid <= 1'b0;
            end else if (s_axi_arvalid) begin
                r_arready <= 1'b1;
            end
        end
    end

    // Write machine: address and data are taken together; the register
    // updates on the acceptance edge, so a read accepted in the same cycle
    // still sees the old value.
    // NOTE: the scratch array is only a few flops, so it is reset like any
    // other state to give defined read-back from power-up.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_aw_wready <= 1'b0;
            r_bvalid    <= 1'b0;
            r_bresp     <= OKAY;
            r_scratch   <= '{default: '0};
        end else begin
            r_aw_wready <= 1'b0;
            if (r_aw_wready) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_wr_bad ? SLVERR : OKAY;
                if (!w_wr_bad && (w_wr_idx >= IDX_W'(2))) begin
                    for (int b = 0; b < 4; b++) begin
                        if (s_axi_wstrb[b])
                            r_scratch[w_wr_idx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
                    end
                end
            end else if (r_bvalid) begin
                if (s_axi_bready)
                    r_bvalid <= 1'b0;
            end else if (s_axi_awvalid && s_axi_wvalid) begin
                r_aw_wready <= 1'b1;
            end
        end
    end

    assign s_axi_arready = r_arready;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rdata   = r_rdata;
    assign s_axi_rresp   = r_rresp;
    assign s_axi_awready = r_aw_wready;
    assign s_axi_wready  = r_aw_wready;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bresp   = r_bresp;

endmodule

// File: rtl/teak_action_stub_ctrl.sv
// ----------------------------------------------------------------------------
// teak_action_stub_ctrl
// Kernel-action stub for bring-up. A go token starts a run: NUM_PARAMS
// words are fetched from the parameter register file (index out, word back),
// summed into a checksum, then after DONE_DELAY idle cycles a done token is
// offered. Each accepted done token bumps the run counter. Checksum and run
// counter are readable over AXI-lite; SMI ports are tied off.
//
// Ports:
//   clk, reset                       clock, asynchronous active-high reset
//   go_0Ready / go_0Stop             go token in
//   done_0Ready / done_0Stop         done token out
//   paramaddr_0Ready/Data/Stop       parameter index out
//   paramdata_0Ready/Data/Stop       parameter word in
//   s_axi_*                          AXI-lite slave (cache/prot unused)
//   smi_req_* / smi_resp_*           SMI port pairs, outputs held at 0
// ----------------------------------------------------------------------------
module teak_action_stub_ctrl
    import teak_action_stub_pkg::*;
#(
    parameter int NUM_PARAMS = 2,
    parameter int DONE_DELAY = 4,
    parameter int AXI_REGS   = 4,
    parameter int SMI_PORTS  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    go_0Ready,
    output logic                    go_0Stop,
    output logic                    done_0Ready,
    input  logic                    done_0Stop,
    output logic                    paramaddr_0Ready,
    output logic [31:0]             paramaddr_0Data,
    input  logic                    paramaddr_0Stop,
    input  logic                    paramdata_0Ready,
    input  logic [31:0]             paramdata_0Data,
    output logic                    paramdata_0Stop,
    input  logic [31:0]             s_axi_araddr,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    input  logic [3:0]              s_axi_arcache,
    input  logic [2:0]              s_axi_arprot,
    output logic [31:0]             s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,
    input  logic [31:0]             s_axi_awaddr,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [3:0]              s_axi_awcache,
    input  logic [2:0]              s_axi_awprot,
    input  logic [31:0]             s_axi_wdata,
    input  logic [3:0]              s_axi_wstrb,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    output logic [SMI_PORTS-1:0]    smi_req_ready,
    output logic [8*SMI_PORTS-1:0]  smi_req_eofc,
    output logic [64*SMI_PORTS-1:0] smi_req_data,
    input  logic [SMI_PORTS-1:0]    smi_req_stop,
    input  logic [SMI_PORTS-1:0]    smi_resp_ready,
    input  logic [8*SMI_PORTS-1:0]  smi_resp_eofc,
    input  logic [64*SMI_PORTS-1:0] smi_resp_data,
    output logic [SMI_PORTS-1:0]    smi_resp_stop
);

    // Terminal values; only meaningful when the matching count is non-zero.
    localparam logic [7:0]  LAST_INDEX = 8'(NUM_PARAMS - 1);
    localparam logic [15:0] DELAY_LAST = 16'(DONE_DELAY - 1);
    // A zero delay skips DELAY entirely; a zero parameter count skips fetching.
    localparam state_t AFTER_FETCH = (DONE_DELAY == 0) ? ST_DONE : ST_DELAY;
    localparam state_t AFTER_GO    = (NUM_PARAMS == 0) ? AFTER_FETCH : ST_FETCH_ADDR;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_checksum;
    logic [31:0] r_run_count;
    logic [7:0]  r_index;
    logic [15:0] r_delay_cnt;
    logic        w_unused;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next           = r_state;
        go_0Stop         = 1'b1;
        paramaddr_0Ready = 1'b0;
        paramdata_0Stop  = 1'b1;
        done_0Ready      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                go_0Stop = 1'b0;
                if (go_0Ready)
                    w_next = AFTER_GO;
            end
            ST_FETCH_ADDR: begin
                paramaddr_0Ready = 1'b1;
                if (!paramaddr_0Stop)
                    w_next = ST_FETCH_DATA;
            end
            ST_FETCH_DATA: begin
                paramdata_0Stop = 1'b0;
                if (paramdata_0Ready)
                    w_next = (r_index == LAST_INDEX) ? AFTER_FETCH : ST_FETCH_ADDR;
            end
            ST_DELAY: begin
                if (r_delay_cnt == DELAY_LAST)
                    w_next = ST_DONE;
            end
            ST_DONE: begin
                done_0Ready = 1'b1;
                if (!done_0Stop)
                    w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Datapath keyed on the current state; each update happens on the same
    // edge as the token transfer that triggers it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_checksum  <= '0;
            r_run_count <= '0;
            r_index     <= '0;
            r_delay_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (go_0Ready) begin
                        r_checksum  <= '0;
                        r_index     <= '0;
                        r_delay_cnt <= '0;
                    end
                end
                ST_FETCH_DATA: begin
                    if (paramdata_0Ready) begin
                        r_checksum <= r_checksum + paramdata_0Data;
                        r_index    <= r_index + 8'd1;
                    end
                end
                ST_DELAY: r_delay_cnt <= r_delay_cnt + 16'd1;
                ST_DONE: begin
                    if (!done_0Stop)
                        r_run_count <= r_run_count + 32'd1;
                end
                default: ;
            endcase
        end
    end

    assign paramaddr_0Data = {24'd0, r_index};

    teak_action_stub_axi_regs #(
        .AXI_REGS (AXI_REGS)
    ) u_axi_regs (
        .clk           (clk),
        .reset         (reset),
        .i_checksum    (r_checksum),
        .i_run_count   (r_run_count),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready)
    );

    // SMI is not used by this stub: all outputs idle, all inputs ignored.
    assign smi_req_ready = '0;
    assign smi_req_eofc  = '0;
    assign smi_req_data  = '0;
    assign smi_resp_stop = '0;

    assign w_unused = ^{s_axi_arcache, s_axi_arprot, s_axi_awcache, s_axi_awprot,
                        smi_req_stop, smi_resp_ready, smi_resp_eofc, smi_resp_data};

endmodule

// File: tb/tb_teak_action_stub_ctrl.sv
// ----------------------------------------------------------------------------
// tb_teak_action_stub_ctrl
// Directed bench: main instance uses NUM_PARAMS=2, DONE_DELAY=4, AXI_REGS=4;
// a second instance uses NUM_PARAMS=0, DONE_DELAY=0. Inputs change and
// outputs are checked on the falling clock edge; cycle n of a run is the
// n-th falling edge after the one where go is driven (cycle 0).
// ----------------------------------------------------------------------------
module tb_teak_action_stub_ctrl;
    import teak_action_stub_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    // Main instance signals
    logic        go_0Ready, go_0Stop, done_0Ready, done_0Stop;
    logic        paramaddr_0Ready, paramaddr_0Stop;
    logic [31:0] paramaddr_0Data;
    logic        paramdata_0Ready, paramdata_0Stop;
    logic [31:0] paramdata_0Data;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic        arvalid, arready, rvalid, rready;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [1:0]  rresp, bresp;
    logic [3:0]  wstrb;
    logic [1:0]  smi_req_ready, smi_resp_stop;
    logic [15:0] smi_req_eofc;
    logic [127:0] smi_req_data;

    // Zero-parameter instance signals
    logic        z_go_ready, z_go_stop, z_done_ready, z_pa_ready, z_pd_stop;
    logic [31:0] z_pa_data, z_rdata;
    logic        z_arready, z_rvalid, z_awready, z_wready, z_bvalid;
    logic [1:0]  z_rresp, z_bresp, z_smi_ready, z_smi_stop;
    logic [15:0] z_smi_eofc;
    logic [127:0] z_smi_data;

    int total = 0;
    int bad   = 0;

    teak_action_stub_ctrl #(
        .NUM_PARAMS (2), .DONE_DELAY (4), .AXI_REGS (4), .SMI_PORTS (2)
    ) dut (
        .clk (clk), .reset (reset),
        .go_0Ready (go_0Ready), .go_0Stop (go_0Stop),
        .done_0Ready (done_0Ready), .done_0Stop (done_0Stop),
        .paramaddr_0Ready (paramaddr_0Ready), .paramaddr_0Data (paramaddr_0Data),
        .paramaddr_0Stop (paramaddr_0Stop),
        .paramdata_0Ready (paramdata_0Ready), .paramdata_0Data (paramdata_0Data),
        .paramdata_0Stop (paramdata_0Stop),
        .s_axi_araddr (araddr), .s_axi_arvalid (arvalid), .s_axi_arready (arready),
        .s_axi_arcache (4'd0), .s_axi_arprot (3'd0),
        .s_axi_rdata (rdata), .s_axi_rresp (rresp), .s_axi_rvalid (rvalid),
        .s_axi_rready (rready),
        .s_axi_awaddr (awaddr), .s_axi_awvalid (awvalid), .s_axi_awready (awready),
        .s_axi_awcache (4'd0), .s_axi_awprot (3'd0),
        .s_axi_wdata (wdata), .s_axi_wstrb (wstrb), .s_axi_wvalid (wvalid),
        .s_axi_wready (wready),
        .s_axi_bresp (bresp), .s_axi_bvalid (bvalid), .s_axi_bready (bready),
        .smi_req_ready (smi_req_ready), .smi_req_eofc (smi_req_eofc),
        .smi_req_data (smi_req_data), .smi_req_stop (2'b00),
        .smi_resp_ready (2'b00), .smi_resp_eofc (16'd0), .smi_resp_data (128'd0),
        .smi_resp_stop (smi_resp_stop)
    );

    teak_action_stub_ctrl #(
        .NUM_PARAMS (0), .DONE_DELAY (0), .AXI_REGS (4), .SMI_PORTS (2)
    ) dut0 (
        .clk (clk), .reset (reset),
        .go_0Ready (z_go_ready), .go_0Stop (z_go_stop),
        .done_0Ready (z_done_ready), .done_0Stop (1'b0),
        .paramaddr_0Ready (z_pa_ready), .paramaddr_0Data (z_pa_data),
        .paramaddr_0Stop (1'b0),
        .paramdata_0Ready (1'b0), .paramdata_0Data (32'd0),
        .paramdata_0Stop (z_pd_stop),
        .s_axi_araddr (32'd0), .s_axi_arvalid (1'b0), .s_axi_arready (z_arready),
        .s_axi_arcache (4'd0), .s_axi_arprot (3'd0),
        .s_axi_rdata (z_rdata), .s_axi_rresp (z_rresp), .s_axi_rvalid (z_rvalid),
        .s_axi_rready (1'b0),
        .s_axi_awaddr (32'd0), .s_axi_awvalid (1'b0), .s_axi_awready (z_awready),
        .s_axi_awcache (4'd0), .s_axi_awprot (3'd0),
        .s_axi_wdata (32'd0), .s_axi_wstrb (4'd0), .s_axi_wvalid (1'b0),
        .s_axi_wready (z_wready),
        .s_axi_bresp (z_bresp), .s_axi_bvalid (z_bvalid), .s_axi_bready (1'b0),
        .smi_req_ready (z_smi_ready), .smi_req_eofc (z_smi_eofc),
        .smi_req_data (z_smi_data), .smi_req_stop (2'b00),
        .smi_resp_ready (2'b00), .smi_resp_eofc (16'd0), .smi_resp_data (128'd0),
        .smi_resp_stop (z_smi_stop)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(negedge clk);
    endtask

    task automatic axi_read(input string tag, input logic [31:0] addr,
                            input logic [31:0] exp_data, input logic [1:0] exp_resp);
        araddr  = addr;
        arvalid = 1'b1;
        step;
        check({tag, " arready"}, 32'(arready), 32'd1);
        step;
        arvalid = 1'b0;
        check({tag, " rvalid"}, 32'(rvalid), 32'd1);
        check({tag, " rdata"}, rdata, exp_data);
        check({tag, " rresp"}, 32'(rresp), 32'(exp_resp));
        rready = 1'b1;
        step;
        rready = 1'b0;
    endtask

    task automatic axi_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [1:0] exp_resp);
        awaddr  = addr;
        wdata   = data;
        wstrb   = strb;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        step;
        check({tag, " aw/wready"}, 32'({awready, wready}), 32'd3);
        step;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        check({tag, " bvalid"}, 32'(bvalid), 32'd1);
        check({tag, " bresp"}, 32'(bresp), 32'(exp_resp));
        bready = 1'b1;
        step;
        bready = 1'b0;
    endtask

    // Drives go in cycle 0 and a zero-wait parameter responder through
    // cycle 8; returns at cycle 9 where done_0Ready must have risen.
    task automatic run_params(input string tag, input logic [31:0] d0, input logic [31:0] d1);
        go_0Ready = 1'b1;
        check({tag, " c0 go_0Stop"}, 32'(go_0Stop), 32'd0);
        step;
        go_0Ready = 1'b0;
        check({tag, " c1 paramaddr ready"}, 32'(paramaddr_0Ready), 32'd1);
        check({tag, " c1 paramaddr data"}, paramaddr_0Data, 32'd0);
        check({tag, " c1 go_0Stop"}, 32'(go_0Stop), 32'd1);
        step;
        check({tag, " c2 paramdata stop"}, 32'(paramdata_0Stop), 32'd0);
        paramdata_0Data = d0;
        step;
        check({tag, " c3 paramaddr ready"}, 32'(paramaddr_0Ready), 32'd1);
        check({tag, " c3 paramaddr data"}, paramaddr_0Data, 32'd1);
        step;
        check({tag, " c4 paramdata stop"}, 32'(paramdata_0Stop), 32'd0);
        paramdata_0Data = d1;
        for (int i = 5; i <= 8; i++) begin
            step;
            check($sformatf("%s c%0d done early", tag, i), 32'(done_0Ready), 32'd0);
        end
        step;
        check({tag, " c9 done_0Ready"}, 32'(done_0Ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        go_0Ready = 0; done_0Stop = 0; paramaddr_0Stop = 0;
        paramdata_0Ready = 1; paramdata_0Data = 0;
        araddr = 0; arvalid = 0; rready = 0;
        awaddr = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0; bready = 0;
        z_go_ready = 0;

        // Reset values
        #1 reset = 1'b1;
        #2;
        check("rst go_0Stop", 32'(go_0Stop), 32'd0);
        check("rst paramdata_0Stop", 32'(paramdata_0Stop), 32'd1);
        check("rst readies", 32'({done_0Ready, paramaddr_0Ready, arready, rvalid,
                                   awready, wready, bvalid}), 32'd0);
        check("rst resp", 32'({rresp, bresp}), 32'd0);
        check("rst smi", 32'({|smi_req_ready, |smi_req_eofc, |smi_req_data, |smi_resp_stop}), 32'd0);
        step;
        reset = 1'b0;
        step;

        // Run 1: 0x10 + 0x20, done taken immediately
        run_params("run1", 32'h10, 32'h20);
        step;
        check("run1 c10 done_0Ready", 32'(done_0Ready), 32'd0);
        check("run1 c10 go_0Stop", 32'(go_0Stop), 32'd0);
        axi_read("rd chk1", 32'h0, 32'h30, OKAY);
        axi_read("rd run1", 32'h4, 32'h1, OKAY);

        // Run 2: wrapping checksum and a stalled done token
        done_0Stop = 1'b1;
        run_params("run2", 32'hFFFF_FFFF, 32'h2);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("stall%0d done_0Ready", i), 32'(done_0Ready), 32'd1);
            check($sformatf("stall%0d go_0Stop", i), 32'(go_0Stop), 32'd1);
            step;
        end
        axi_read("rd run stalled", 32'h4, 32'h1, OKAY);
        check("stall done held", 32'(done_0Ready), 32'd1);
        done_0Stop = 1'b0;
        step;
        check("stall released", 32'(done_0Ready), 32'd0);
        axi_read("rd run2", 32'h4, 32'h2, OKAY);
        axi_read("rd chk wrap", 32'h0, 32'h1, OKAY);

        // Zero parameters, zero delay
        z_go_ready = 1'b1;
        check("z c0 go_stop", 32'(z_go_stop), 32'd0);
        check("z c0 paramaddr", 32'(z_pa_ready), 32'd0);
        step;
        z_go_ready = 1'b0;
        check("z c1 done_ready", 32'(z_done_ready), 32'd1);
        check("z c1 paramaddr", 32'(z_pa_ready), 32'd0);
        step;
        check("z c2 done_ready", 32'(z_done_ready), 32'd0);
        check("z c2 go_stop", 32'(z_go_stop), 32'd0);

        // Scratch byte strobes, read-only write, bad addresses
        axi_write("wr scratch", 32'h8, 32'hAABB_CCDD, 4'b0101, OKAY);
        axi_read("rd scratch", 32'h8, 32'h00BB_00DD, OKAY);
        axi_write("wr scratch hi", 32'hC, 32'h1234_5678, 4'b1111, OKAY);
        axi_read("rd scratch hi", 32'hC, 32'h1234_5678, OKAY);
        axi_write("wr ro", 32'h0, 32'hDEAD_BEEF, 4'b1111, OKAY);
        axi_read("rd ro", 32'h0, 32'h1, OKAY);
        axi_read("rd bad", 32'h10, 32'h0, SLVERR);
        axi_write("wr bad", 32'h10, 32'h5555_5555, 4'b1111, SLVERR);
        axi_read("rd after bad wr", 32'h8, 32'h00BB_00DD, OKAY);

        // Reset while waiting in the second FETCH_DATA
        go_0Ready = 1'b1;
        step;
        go_0Ready = 1'b0;
        step;
        paramdata_0Data = 32'h5;
        step;
        check("abort c3 paramaddr data", paramaddr_0Data, 32'd1);
        step;
        paramdata_0Ready = 1'b0;
        check("abort c4 paramdata stop", 32'(paramdata_0Stop), 32'd0);
        #2 reset = 1'b1;
        #1;
        check("abort paramdata_0Stop", 32'(paramdata_0Stop), 32'd1);
        check("abort go_0Stop", 32'(go_0Stop), 32'd0);
        check("abort paramaddr", 32'({paramaddr_0Ready, done_0Ready}), 32'd0);
        check("abort paramaddr data", paramaddr_0Data, 32'd0);
        step;
        reset = 1'b0;
        paramdata_0Ready = 1'b1;
        step;
        axi_read("rd chk reset", 32'h0, 32'h0, OKAY);
        axi_read("rd run reset", 32'h4, 32'h0, OKAY);
        axi_read("rd scratch reset", 32'h8, 32'h0, OKAY);
        run_params("run3", 32'h3, 32'h4);
        step;
        check("run3 done taken", 32'(done_0Ready), 32'd0);
        axi_read("rd chk3", 32'h0, 32'h7, OKAY);
        axi_read("rd run3", 32'h4, 32'h1, OKAY);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/teak_action_stub_ctrl.md
# teak_action_stub_ctrl

Parametrised kernel-action stub for SDAccel bring-up. It accepts a go token and fetches NUM_PARAMS words from the parameter register file over the SELF address/data channels. It then waits a programmable delay and issues a done token. An AXI-lite slave exposes the parameter checksum, a run counter and scratch registers; SMI ports are tied off per port. It sits in the same toplevel slot as a real kernel action.

## Interface
- NUM_PARAMS, 2: parameter words fetched per run (0..255).
- DONE_DELAY, 4: idle cycles between last fetch and done (0..65535).
- AXI_REGS, 4: AXI-lite registers, power of two, ≥4.
- SMI_PORTS, 2: number of SMI req/resp port pairs.
- clk  in  1  clock. Single clock domain.
- reset  in  1  asynchronous, active-high reset.
- go_0Ready in 1 / go_0Stop out 1  go token.
- done_0Ready out 1 / done_0Stop in 1  done token.
- paramaddr_0Ready out 1 / paramaddr_0Data out 32 / paramaddr_0Stop in 1  parameter word index.
- paramdata_0Ready in 1 / paramdata_0Data in 32 / paramdata_0Stop out 1  parameter word.
- s_axi_ar*, r*, aw*, w*, b*  AXI-lite slave, 32-bit address/data; cache/prot inputs unused.
- smi_req_ready out SMI_PORTS / smi_req_eofc out 8*SMI_PORTS / smi_req_data out 64*SMI_PORTS / smi_req_stop in SMI_PORTS  SMI request side.
- smi_resp_ready in SMI_PORTS / smi_resp_eofc in 8*SMI_PORTS / smi_resp_data in 64*SMI_PORTS / smi_resp_stop out SMI_PORTS  SMI response side.

## Operation
- A SELF token transfers in any cycle where Ready=1 and Stop=0.
- FSM states are IDLE, FETCH_ADDR, FETCH_DATA, DELAY and DONE.
- IDLE:
  - go_0Stop=0.
  - When a go token transfers: clear checksum and param index, then go to FETCH_ADDR. If NUM_PARAMS=0, go to DELAY instead.
- FETCH_ADDR:
  - paramaddr_0Ready=1 and paramaddr_0Data=index, zero-extended.
  - When the address transfers, go to FETCH_DATA.
- FETCH_DATA:
  - paramdata_0Stop=0; it is 1 in every other state.
  - When the data transfers: checksum += data (mod 2^32) and index++.
  - If this was the last word, go to DELAY; otherwise go to FETCH_ADDR.
- DELAY:
  - Count DONE_DELAY cycles, then go to DONE.
  - If DONE_DELAY=0, go straight to DONE without entering DELAY.
- DONE:
  - done_0Ready=1.
  - When the done token transfers: run counter++ (wraps at 2^32), then go to IDLE.
- go_0Stop=1 in every state except IDLE.
- AXI register map, word-indexed by addr[2+:log2(AXI_REGS)]:
  - Index 0: checksum, read-only.
  - Index 1: run counter, read-only.
  - Index 2..AXI_REGS-1: scratch, read/write, honouring wstrb per byte.
- Writes to read-only registers are ignored and return OKAY.
- Any address ≥ 4*AXI_REGS returns SLVERR (2'b10): reads return data 0, writes have no effect.
- AXI reads and writes are independent machines, each with one transaction outstanding.
- SMI outputs are tied off: req_ready, eofc, data and resp_stop are all 0.

## Timing
- Reset values:
  - FSM=IDLE; checksum, index, delay count, run counter and scratch all 0.
  - All Ready/valid/arready/awready/wready outputs 0.
  - go_0Stop=0; paramdata_0Stop=1; rresp/bresp=0.
- Reset asserted mid-run aborts immediately to IDLE with the reset values; no done token is issued.
- Latency with a zero-wait parameter responder (go accepted in cycle 0):
  - Address k is presented in cycle 2k+1 and its data is accepted in cycle 2k+2.
  - done_0Ready rises in cycle 2·NUM_PARAMS+1+DONE_DELAY.
- done_0Ready stays high while done_0Stop=1.
- AXI read:
  - arvalid seen in cycle t gives arready=1 for exactly cycle t+1; rdata is captured in that cycle.
  - rvalid rises in cycle t+2 and is held until rready. A new ar is not accepted until the r handshake completes.
- AXI write:
  - Requires awvalid and wvalid together in cycle t.
  - awready and wready are high together in cycle t+1; the register updates at the end of t+1.
  - bvalid rises in t+2 and is held until bready.
- A same-cycle read and write of one scratch register returns the old value.

## Structure
- Package teak_action_stub_pkg holds:
  - the FSM state enum;
  - register index constants CHECKSUM_IDX=0 and RUNCOUNT_IDX=1;
  - AXI response codes OKAY and SLVERR.
- Sub-module teak_action_stub_axi_regs holds the AXI-lite slave and scratch array. Its inputs are checksum and run counter.
- The FSM, counters and SMI tie-offs stay in the top module.

## Test plan
- NUM_PARAMS=2, DONE_DELAY=4, data 0x10 and 0x20 with zero wait:
  - paramaddr shows 0 in cycle 1 and 1 in cycle 3.
  - done_0Ready rises in cycle 9.
  - AXI read of 0x0 returns 0x30; read of 0x4 returns 1.
- done_0Stop held high for 5 cycles:
  - done_0Ready stays 1 and go_0Stop stays 1.
  - Run counter increments only on the transfer.
- NUM_PARAMS=0, DONE_DELAY=0: go accepted in cycle 0 gives done_0Ready in cycle 1 and no paramaddr activity.
- Data words 0xFFFFFFFF and 0x2 give checksum 0x1.
- AXI scratch writes and bad address:
  - Write 0xAABBCCDD with wstrb 0b0101 to 0x8 from reset 0: read of 0x8 returns 0x00BB00DD.
  - Write to 0x0: OKAY, checksum unchanged.
  - Read of 0x10 with AXI_REGS=4: SLVERR and data 0.
- Reset asserted while in FETCH_DATA:
  - All outputs return to their reset values asynchronously.
  - The next go performs a full fresh run.
